// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-requester arbiter between the L1 caches and the
// single tagged main-memory port, with a tag-owner table for returns.
//
// Ports:
//   clock, reset         clock; asynchronous active-high reset
//   req_command/size/    per-requester command, size, address, store data
//   addr/data
//   req_response         per-requester copy of mem response (granted only)
//   rsp_valid            one-hot owner of the returning tag
//   rsp_tag, rsp_data    pass-through of the returning tag and data
//   arb2mem_*            granted request to memory
//   mem2arb_response     tag assigned by memory (0 = rejected)
//   mem2arb_tag/data     returning tag (0 = none) and data
//   stray_tag_err        sticky: a tag came back with no recorded owner

package mem_arbiter_rr_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        MEM_BYTE   = 2'h0,
        MEM_HALF   = 2'h1,
        MEM_WORD   = 2'h2,
        MEM_DOUBLE = 2'h3
    } MEM_SIZE;
endpackage

module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_TAGS = 15,
    parameter int RR_MODE  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  BUS_COMMAND        req_command  [NUM_REQ],
    input  MEM_SIZE           req_size     [NUM_REQ],
    input  logic [XLEN-1:0]   req_addr     [NUM_REQ],
    input  logic [2*XLEN-1:0] req_data     [NUM_REQ],
    output logic [3:0]        req_response [NUM_REQ],
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [3:0]        rsp_tag,
    output logic [63:0]       rsp_data,
    output BUS_COMMAND        arb2mem_command,
    output MEM_SIZE           arb2mem_size,
    output logic [XLEN-1:0]   arb2mem_addr,
    output logic [2*XLEN-1:0] arb2mem_data,
    input  logic [3:0]        mem2arb_response,
    input  logic [3:0]        mem2arb_tag,
    input  logic [63:0]       mem2arb_data,
    output logic              stray_tag_err
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] cand;
    logic               found;
    logic [ID_W-1:0]    gnt;
    logic [ID_W-1:0]    idx;
    logic [ID_W-1:0]    rr_ptr;
    logic               stk_vld;
    logic [ID_W-1:0]    stk_id;
    int                 base_idx;

    logic [ID_W-1:0]    owner  [1:NUM_TAGS];
    logic               ovalid [1:NUM_TAGS];

    logic               hit;
    logic [ID_W-1:0]    hit_id;
    logic               stray;
    logic               accept;
    logic               acc_load;

    // Grant: a rejected requester that still asks keeps the grant,
    // otherwise scan from the base (rr_ptr in RR mode, 0 in fixed).
    always_comb begin
        cand     = '0;
        found    = 1'b0;
        gnt      = '0;
        idx      = '0;
        base_idx = (RR_MODE != 0) ? int'(rr_ptr) : 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand[i] = (req_command[i] != BUS_NONE);
        end
        if (stk_vld && cand[stk_id]) begin
            found = 1'b1;
            gnt   = stk_id;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = ID_W'((base_idx + i) % NUM_REQ);
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    gnt   = idx;
                end
            end
        end
    end

    always_comb begin
        arb2mem_command = BUS_NONE;
        arb2mem_size    = MEM_BYTE;
        arb2mem_addr    = '0;
        arb2mem_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_response[i] = '0;
        end
        if (found && !reset) begin
            arb2mem_command   = req_command[gnt];
            arb2mem_size      = req_size[gnt];
            arb2mem_addr      = req_addr[gnt];
            arb2mem_data      = req_data[gnt];
            req_response[gnt] = mem2arb_response;
        end
    end

    assign accept   = found && !reset && (mem2arb_response != '0);
    assign acc_load = accept && (req_command[gnt] == BUS_LOAD);

    // Return routing uses the pre-edge owner table; tags outside
    // 1..NUM_TAGS never match and so count as stray.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int t = 1; t <= NUM_TAGS; t++) begin
            if (mem2arb_tag == 4'(t) && ovalid[t]) begin
                hit    = 1'b1;
                hit_id = owner[t];
            end
        end
        stray     = (mem2arb_tag != '0) && !hit;
        rsp_valid = '0;
        if (hit && !reset) begin
            rsp_valid[hit_id] = 1'b1;
        end
        rsp_tag  = reset ? 4'h0 : mem2arb_tag;
        rsp_data = reset ? 64'h0 : mem2arb_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int t = 1; t <= NUM_TAGS; t++) begin
                ovalid[t] <= 1'b0;
                owner[t]  <= '0;
            end
            rr_ptr        <= '0;
            stk_vld       <= 1'b0;
            stk_id        <= '0;
            stray_tag_err <= 1'b0;
        end else begin
            if (stray) begin
                stray_tag_err <= 1'b1;
            end
            // Clear first, then a same-tag acceptance overrides it.
            for (int t = 1; t <= NUM_TAGS; t++) begin
                if (hit && mem2arb_tag == 4'(t)) begin
                    ovalid[t] <= 1'b0;
                end
                if (acc_load && mem2arb_response == 4'(t)) begin
                    ovalid[t] <= 1'b1;
                    owner[t]  <= gnt;
                end
            end
            if (found) begin
                stk_vld <= (mem2arb_response == '0);
                stk_id  <= gnt;
            end else begin
                stk_vld <= 1'b0;
            end
            if (RR_MODE != 0 && accept) begin
                rr_ptr <= ID_W'((int'(gnt) + 1) % NUM_REQ);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed and random stimulus for a fixed-priority
// (2 requesters) and a round-robin (4 requesters) arbiter instance.

module tb_mem_arbiter_rr;
    import mem_arbiter_rr_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // bench-side stimulus, index 0 = fixed DUT, 1 = round-robin DUT
    BUS_COMMAND        g_cmd   [2][4];
    MEM_SIZE           g_size  [2][4];
    logic [XLEN-1:0]   g_addr  [2][4];
    logic [2*XLEN-1:0] g_wdat  [2][4];
    logic [3:0]        g_mresp [2];
    logic [3:0]        g_mtag  [2];
    logic [63:0]       g_mdat  [2];

    BUS_COMMAND        f_cmd [2];
    MEM_SIZE           f_size[2];
    logic [XLEN-1:0]   f_addr[2];
    logic [2*XLEN-1:0] f_wdat[2];
    logic [3:0]        f_resp[2];
    logic [1:0]        f_rv;
    logic [3:0]        f_rtag;
    logic [63:0]       f_rdat;
    BUS_COMMAND        f_mcmd;
    MEM_SIZE           f_msize;
    logic [XLEN-1:0]   f_maddr;
    logic [2*XLEN-1:0] f_mdat;
    logic              f_err;

    BUS_COMMAND        r_cmd [4];
    MEM_SIZE           r_size[4];
    logic [XLEN-1:0]   r_addr[4];
    logic [2*XLEN-1:0] r_wdat[4];
    logic [3:0]        r_resp[4];
    logic [3:0]        r_rv;
    logic [3:0]        r_rtag;
    logic [63:0]       r_rdat;
    BUS_COMMAND        r_mcmd;
    MEM_SIZE           r_msize;
    logic [XLEN-1:0]   r_maddr;
    logic [2*XLEN-1:0] r_mdat;
    logic              r_err;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            f_cmd[i]  = g_cmd[0][i];
            f_size[i] = g_size[0][i];
            f_addr[i] = g_addr[0][i];
            f_wdat[i] = g_wdat[0][i];
        end
        for (int i = 0; i < 4; i++) begin
            r_cmd[i]  = g_cmd[1][i];
            r_size[i] = g_size[1][i];
            r_addr[i] = g_addr[1][i];
            r_wdat[i] = g_wdat[1][i];
        end
    end

    mem_arbiter_rr #(.NUM_REQ(2), .NUM_TAGS(15), .RR_MODE(0)) u_fix (
        .clock(clock), .reset(reset),
        .req_command(f_cmd), .req_size(f_size),
        .req_addr(f_addr), .req_data(f_wdat),
        .req_response(f_resp), .rsp_valid(f_rv),
        .rsp_tag(f_rtag), .rsp_data(f_rdat),
        .arb2mem_command(f_mcmd), .arb2mem_size(f_msize),
        .arb2mem_addr(f_maddr), .arb2mem_data(f_mdat),
        .mem2arb_response(g_mresp[0]), .mem2arb_tag(g_mtag[0]),
        .mem2arb_data(g_mdat[0]), .stray_tag_err(f_err)
    );

    mem_arbiter_rr #(.NUM_REQ(4), .NUM_TAGS(15), .RR_MODE(1)) u_rr (
        .clock(clock), .reset(reset),
        .req_command(r_cmd), .req_size(r_size),
        .req_addr(r_addr), .req_data(r_wdat),
        .req_response(r_resp), .rsp_valid(r_rv),
        .rsp_tag(r_rtag), .rsp_data(r_rdat),
        .arb2mem_command(r_mcmd), .arb2mem_size(r_msize),
        .arb2mem_addr(r_maddr), .arb2mem_data(r_mdat),
        .mem2arb_response(g_mresp[1]), .mem2arb_tag(g_mtag[1]),
        .mem2arb_data(g_mdat[1]), .stray_tag_err(r_err)
    );

    // reference model: who owns each tag (-1 = nobody), pointer, sticky
    int nr[2] = '{2, 4};
    int md[2] = '{0, 1};
    int m_ptr[2];
    int m_stk[2];
    int m_own[2][16];
    bit m_err[2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [127:0] obs, logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int exp_grant(int d);
        int j;
        if (m_stk[d] >= 0 && g_cmd[d][m_stk[d]] != BUS_NONE)
            return m_stk[d];
        for (int k = 0; k < nr[d]; k++) begin
            j = ((md[d] != 0 ? m_ptr[d] : 0) + k) % nr[d];
            if (g_cmd[d][j] != BUS_NONE) return j;
        end
        return -1;
    endfunction

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0;
            m_stk[d] = -1;
            m_err[d] = 1'b0;
            for (int t = 0; t < 16; t++) m_own[d][t] = -1;
        end
    endtask

    task automatic update_model(int d);
        int g;
        int t;
        int r;
        g = exp_grant(d);
        t = int'(g_mtag[d]);
        r = int'(g_mresp[d]);
        if (t != 0) begin
            if (m_own[d][t] >= 0) m_own[d][t] = -1;
            else m_err[d] = 1'b1;
        end
        if (g < 0) begin
            m_stk[d] = -1;
        end else if (r == 0) begin
            m_stk[d] = g;
        end else begin
            if (g_cmd[d][g] == BUS_LOAD) m_own[d][r] = g;
            if (md[d] != 0) m_ptr[d] = (g + 1) % nr[d];
            m_stk[d] = -1;
        end
    endtask

    task automatic check_dut(int d);
        int g;
        int t;
        BUS_COMMAND ocmd;
        BUS_COMMAND ecmd;
        MEM_SIZE osz;
        MEM_SIZE esz;
        logic [XLEN-1:0] oa;
        logic [XLEN-1:0] ea;
        logic [63:0] od;
        logic [63:0] ed;
        logic [63:0] ordat;
        logic [3:0] orsp[4];
        logic [3:0] orv;
        logic [3:0] ortag;
        logic [3:0] ev;
        logic oerr;
        if (d == 0) begin
            ocmd = f_mcmd; osz = f_msize; oa = f_maddr; od = f_mdat;
            orsp[0] = f_resp[0]; orsp[1] = f_resp[1];
            orsp[2] = 4'h0; orsp[3] = 4'h0;
            orv = {2'b00, f_rv}; ortag = f_rtag;
            ordat = f_rdat; oerr = f_err;
        end else begin
            ocmd = r_mcmd; osz = r_msize; oa = r_maddr; od = r_mdat;
            for (int i = 0; i < 4; i++) orsp[i] = r_resp[i];
            orv = r_rv; ortag = r_rtag;
            ordat = r_rdat; oerr = r_err;
        end
        g = exp_grant(d);
        ecmd = BUS_NONE; esz = MEM_BYTE; ea = '0; ed = '0;
        if (g >= 0) begin
            ecmd = g_cmd[d][g]; esz = g_size[d][g];
            ea = g_addr[d][g]; ed = g_wdat[d][g];
        end
        chk($sformatf("d%0d_cmd", d), ocmd, ecmd);
        chk($sformatf("d%0d_size", d), osz, esz);
        chk($sformatf("d%0d_addr", d), oa, ea);
        chk($sformatf("d%0d_wdata", d), od, ed);
        for (int i = 0; i < nr[d]; i++)
            chk($sformatf("d%0d_req_resp%0d", d, i), orsp[i],
                (i == g) ? g_mresp[d] : 4'h0);
        t = int'(g_mtag[d]);
        ev = 4'h0;
        if (t != 0 && m_own[d][t] >= 0) ev = 4'(1 << m_own[d][t]);
        chk($sformatf("d%0d_rsp_valid", d), orv, ev);
        chk($sformatf("d%0d_rsp_tag", d), ortag, g_mtag[d]);
        chk($sformatf("d%0d_rsp_data", d), ordat, g_mdat[d]);
        chk($sformatf("d%0d_stray", d), oerr, m_err[d]);
    endtask

    task automatic step_a();
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic step_b();
        update_model(0);
        update_model(1);
        @(negedge clock);
    endtask

    task automatic step();
        step_a();
        step_b();
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                g_cmd[d][i]  = BUS_NONE;
                g_size[d][i] = MEM_BYTE;
                g_addr[d][i] = '0;
                g_wdat[d][i] = '0;
            end
            g_mresp[d] = '0;
            g_mtag[d]  = '0;
            g_mdat[d]  = '0;
        end
    endtask

    task automatic chk_zero(string name);
        chk({name, "_fix"},
            {f_mcmd, f_msize, f_maddr, f_resp[0], f_resp[1], f_rv,
             f_rtag, f_err}, '0);
        chk({name, "_fixd"}, {f_mdat, f_rdat}, '0);
        chk({name, "_rr"},
            {r_mcmd, r_msize, r_maddr, r_resp[0], r_resp[1], r_resp[2],
             r_resp[3], r_rv, r_rtag, r_err}, '0);
        chk({name, "_rrd"}, {r_mdat, r_rdat}, '0);
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        #1;
        reset_model();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic all_load_rr();
        for (int i = 0; i < 4; i++) begin
            g_cmd[1][i]  = BUS_LOAD;
            g_addr[1][i] = 32'h100 * (i + 1) + 32'h40;
        end
    endtask

    task automatic rand_cycle(bit allow_stray);
        int g;
        int t;
        int r;
        int q[$];
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nr[d]; i++) begin
                r = $urandom_range(0, 99);
                g_cmd[d][i] = (r < 45) ? BUS_LOAD :
                              (r < 65) ? BUS_STORE : BUS_NONE;
                g_size[d][i] = MEM_SIZE'($urandom_range(0, 3));
                g_addr[d][i] = $urandom;
                g_wdat[d][i] = {$urandom, $urandom};
            end
            q.delete();
            for (int k = 1; k < 16; k++)
                if (m_own[d][k] >= 0) q.push_back(k);
            t = 0;
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                t = q[$urandom_range(0, q.size() - 1)];
            else if (allow_stray && $urandom_range(0, 49) == 0)
                t = $urandom_range(1, 15);
            g_mtag[d] = 4'(t);
            g_mdat[d] = {$urandom, $urandom};
            g = exp_grant(d);
            g_mresp[d] = 4'h0;
            r = $urandom_range(0, 99);
            if (g >= 0 && r >= 25) begin
                if (r < 35 && t != 0) begin
                    g_mresp[d] = 4'(t);
                end else begin
                    q.delete();
                    for (int k = 1; k < 16; k++)
                        if (m_own[d][k] < 0 || k == t) q.push_back(k);
                    if (q.size() > 0)
                        g_mresp[d] = 4'(q[$urandom_range(0, q.size() - 1)]);
                end
            end
        end
        step();
    endtask

    int exp_g[4];
    int resp_s[4];

    initial begin
        reset = 1'b1;
        idle();
        reset_model();
        // reset: outputs forced to zero even with live inputs
        g_cmd[0][0] = BUS_LOAD; g_addr[0][0] = 32'hdead0000;
        all_load_rr();
        g_mresp[0] = 4'h3; g_mtag[0] = 4'h2; g_mdat[0] = 64'h55;
        g_mresp[1] = 4'h3; g_mtag[1] = 4'h2; g_mdat[1] = 64'haa;
        @(negedge clock);
        #1;
        chk_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        idle();

        // fixed priority: Dcache wins, tag 3 later routes to it
        g_cmd[0][0] = BUS_LOAD; g_addr[0][0] = 32'h1000;
        g_cmd[0][1] = BUS_LOAD; g_addr[0][1] = 32'h2000;
        g_mresp[0] = 4'h3;
        step_a();
        chk("fix_addr", f_maddr, 32'h1000);
        chk("fix_resp0", f_resp[0], 4'h3);
        chk("fix_resp1", f_resp[1], 4'h0);
        step_b();
        g_cmd[0][0] = BUS_NONE;
        g_mresp[0] = 4'h0;
        g_mtag[0] = 4'h3; g_mdat[0] = 64'h0123_4567_89ab_cdef;
        step_a();
        chk("fix_route3", f_rv, 2'b01);
        step_b();
        idle();
        step();

        // round robin: 0,1,2,3,0 then 1, reject 2, 2 again, 3
        all_load_rr();
        exp_g  = '{0, 1, 2, 3};
        for (int k = 0; k < 5; k++) begin
            g_mresp[1] = 4'(k + 1);
            step_a();
            chk($sformatf("rr_grant%0d", k), r_maddr,
                32'h100 * ((k % 4) + 1) + 32'h40);
            step_b();
        end
        exp_g  = '{1, 2, 2, 3};
        resp_s = '{6, 0, 7, 8};
        for (int k = 0; k < 4; k++) begin
            g_mresp[1] = 4'(resp_s[k]);
            step_a();
            chk($sformatf("rr_sticky%0d", k), r_maddr,
                32'h100 * (exp_g[k] + 1) + 32'h40);
            step_b();
        end
        idle();

        // interleaved returns: tag 5 -> req1, tag 6 -> req0
        g_cmd[1][1] = BUS_LOAD; g_mresp[1] = 4'h5;
        step();
        idle();
        g_cmd[1][0] = BUS_LOAD; g_mresp[1] = 4'h6;
        step();
        idle();
        g_mtag[1] = 4'h6;
        step_a();
        chk("rr_ret6", r_rv, 4'b0001);
        step_b();
        g_mtag[1] = 4'h5;
        step_a();
        chk("rr_ret5", r_rv, 4'b0010);
        step_b();

        // asynchronous reset with tags 1..4,7,8 outstanding
        idle();
        all_load_rr();
        g_mresp[1] = 4'h9; g_mtag[1] = 4'h2; g_mdat[1] = 64'hfeed;
        #3;
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        reset_model();
        @(negedge clock);
        reset = 1'b0;
        g_mtag[1] = 4'h1;
        step_a();
        chk("post_rst_ptr", r_maddr, 32'h140);
        chk("post_rst_rv", r_rv, 4'b0000);
        step_b();
        idle();
        step_a();
        chk("post_rst_stray", r_err, 1'b1);
        step_b();

        // store accepted as tag 7 records no owner
        sync_reset();
        g_cmd[1][2] = BUS_STORE; g_mresp[1] = 4'h7;
        step();
        idle();
        g_mtag[1] = 4'h7;
        step_a();
        chk("store_rv", r_rv, 4'b0000);
        step_b();
        idle();
        step_a();
        chk("store_stray", r_err, 1'b1);
        step_b();

        // tag 4 returns while being re-issued as tag 4
        sync_reset();
        g_cmd[1][1] = BUS_LOAD; g_mresp[1] = 4'h4;
        step();
        idle();
        g_cmd[1][0] = BUS_LOAD; g_mresp[1] = 4'h4; g_mtag[1] = 4'h4;
        step_a();
        chk("same_tag_old", r_rv, 4'b0010);
        step_b();
        idle();
        g_mtag[1] = 4'h4;
        step_a();
        chk("same_tag_new", r_rv, 4'b0001);
        step_b();

        // random traffic, strays only in the second half
        sync_reset();
        idle();
        for (int c = 0; c < 600; c++) rand_cycle(c >= 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
